// File: rtl/rd_tail_if.sv
// ---------------------------------------------------------------------------
// rd_tail_if : descriptor, storage-read and egress stream bundle for rd_tail
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rd_tail_if #(
  parameter int LEN_W = 12
);
  logic [LEN_W+7:0] data_info;
  logic             data_info_vld;
  logic             info_ovf;
  logic             data_ren;
  logic [7:0]       data_in;
  logic             rd_sop;
  logic             rd_eop;
  logic             rd_vld;
  logic [7:0]       rd_data;
  logic             rd_rdy;
  logic             busy;

  modport master (
    output data_info, data_info_vld, data_in, rd_rdy,
    input  info_ovf, data_ren, rd_sop, rd_eop, rd_vld, rd_data, busy
  );

  modport slave (
    input  data_info, data_info_vld, data_in, rd_rdy,
    output info_ovf, data_ren, rd_sop, rd_eop, rd_vld, rd_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/rd_tail.sv
// ---------------------------------------------------------------------------
// rd_tail : egress packet transmitter, descriptor queue + sop/vld/eop framer.
//           RD_TAIL_HDR_EN defined -> {pri,dest_port} header beat precedes payload.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rd_tail #(
  parameter int INFO_DEPTH = 4,
  parameter int LEN_W      = 12
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  rd_tail_if.slave    bus
);

  localparam int c_AW = $clog2(INFO_DEPTH);
  localparam int c_IW = LEN_W + 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_IW-1:0]   r_info_mem [INFO_DEPTH];
  logic [c_AW:0]     r_wr_ptr;
  logic [c_AW:0]     r_rd_ptr;
  logic              r_ovf;
  logic [LEN_W-1:0]  r_rem;
  logic [7:0]        r_data;
  logic              r_vld;
  logic              r_sop;
  logic              r_eop;
  logic              r_ret;
  logic              r_first;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [c_IW-1:0]   w_head;
  logic [LEN_W-1:0]  w_head_len;
  logic              w_xfer;
  logic              w_ren;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_push     = bus.data_info_vld && !w_full;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_head     = r_info_mem[r_rd_ptr[c_AW-1:0]];
  assign w_head_len = w_head[c_IW-1:8];
  assign w_xfer     = r_vld && bus.rd_rdy;

`ifndef RD_TAIL_HDR_EN
  logic w_unused_hdr;
  assign w_unused_hdr = ^w_head[7:0];
`endif

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_info_mem[r_wr_ptr[c_AW-1:0]] <= bus.data_info;
    end
  end

  // Full is judged before the pop, so a write racing a pop on a full queue is lost.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ovf <= bus.data_info_vld && w_full;
    end
  end

  // A read is only launched when the output register is free next cycle.
  always_comb begin
    w_ren = 1'b0;
    case (r_state)
      S_HDR:   w_ren = w_xfer && (r_rem != '0);
      S_DATA:  w_ren = (r_rem != '0) && bus.rd_rdy && (!r_vld || w_xfer);
      default: w_ren = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_ret   <= 1'b0;
      r_first <= 1'b0;
    end else begin
      if (r_ret) r_data <= bus.data_in;
      r_ret <= w_ren;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_rem <= w_head_len;
`ifdef RD_TAIL_HDR_EN
            r_data  <= w_head[7:0];
            r_vld   <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= (w_head_len == '0);
            r_first <= 1'b0;
            r_state <= S_HDR;
`else
            r_first <= 1'b1;
            if (w_head_len != '0) r_state <= S_DATA;
`endif
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            r_sop <= 1'b0;
            if (r_rem == '0) begin
              r_vld   <= 1'b0;
              r_eop   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_rem   <= r_rem - LEN_W'(1);
              r_eop   <= (r_rem == LEN_W'(1));
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_ren) begin
            r_vld   <= 1'b1;
            r_sop   <= r_first;
            r_first <= 1'b0;
            r_eop   <= (r_rem == LEN_W'(1));
            r_rem   <= r_rem - LEN_W'(1);
          end else if (w_xfer) begin
            r_vld <= 1'b0;
            r_sop <= 1'b0;
            r_eop <= 1'b0;
            if (r_eop) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Returning storage byte is presented directly, then held in r_data.
  assign bus.rd_data  = r_ret ? bus.data_in : r_data;
  assign bus.rd_vld   = r_vld;
  assign bus.rd_sop   = r_sop;
  assign bus.rd_eop   = r_eop;
  assign bus.data_ren = w_ren;
  assign bus.info_ovf = r_ovf;
  assign bus.busy     = (r_state != S_IDLE) || !w_empty;

endmodule

`default_nettype wire
